// File: rtl/rrf_alloc.sv
// rrf_alloc: rename register file with an integrated circular tag allocator, in-order commit and flush.
// Optional macro RRF_WR_BYPASS_EN forwards same-cycle writebacks onto the read and commit ports.
module rrf_alloc #(
    parameter int DATA_LEN = 32,
    parameter int RRF_NUM  = 64,
    parameter int RRF_SEL  = $clog2(RRF_NUM),
    parameter int NRD      = 4,
    parameter int NWR      = 5,
    parameter int NDP      = 2,
    parameter int NCM      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NRD*RRF_SEL-1:0]     rd_tag,
    output logic [NRD*DATA_LEN-1:0]    rd_data,
    output logic [NRD-1:0]             rd_valid,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR*RRF_SEL-1:0]     wr_tag,
    input  logic [NWR*DATA_LEN-1:0]    wr_data,
    input  logic [$clog2(NDP+1)-1:0]   dp_req,
    output logic                       dp_ack,
    output logic [NDP*RRF_SEL-1:0]     dp_tag,
    input  logic [$clog2(NCM+1)-1:0]   com_num,
    output logic [NCM*DATA_LEN-1:0]    com_data,
    output logic [NCM-1:0]             com_valid,
    input  logic                       flush,
    output logic [RRF_SEL:0]           free_cnt,
    output logic [RRF_SEL-1:0]         rrf_head,
    output logic [RRF_SEL-1:0]         rrf_tail
);
    localparam int CW = RRF_SEL + 1;

    logic [DATA_LEN-1:0] r_data [RRF_NUM];
    logic [RRF_NUM-1:0]  r_valid;
    logic [RRF_SEL-1:0]  r_head;
    logic [RRF_SEL-1:0]  r_tail;
    logic [CW-1:0]       r_used;

    logic [CW-1:0]       w_req;
    logic [CW-1:0]       w_com_lim;
    logic [CW-1:0]       w_com;
    logic [CW-1:0]       w_free;
    logic                w_ack;
    logic                w_alloc;
    logic [RRF_SEL-1:0]  w_head_nxt;
    logic [RRF_SEL-1:0]  w_tail_nxt;
    logic [CW-1:0]       w_used_nxt;
    logic [RRF_NUM-1:0]  w_valid_nxt;
    logic [RRF_SEL-1:0]  w_off_h;
    logic [RRF_SEL-1:0]  w_off_t;

    assign w_free = CW'(RRF_NUM) - r_used;

    // Clamp dispatch to NDP and commit to NCM and to the number of occupied entries.
    always_comb begin
        w_req     = (CW'(dp_req) > CW'(NDP)) ? CW'(NDP) : CW'(dp_req);
        w_com_lim = (CW'(com_num) > CW'(NCM)) ? CW'(NCM) : CW'(com_num);
        w_com     = (w_com_lim > r_used) ? r_used : w_com_lim;
    end

    // Entries retired this cycle are already available to the same-cycle dispatch.
    assign w_ack   = ~flush & (w_req <= (w_free + w_com));
    assign w_alloc = w_ack & (w_req != CW'(0));

    // Next pointers, occupancy and valid bits: writeback sets, then flush/allocation clears.
    always_comb begin
        w_head_nxt  = r_head + RRF_SEL'(w_com);
        w_valid_nxt = r_valid;
        w_off_h     = '0;
        w_off_t     = '0;
        if (flush) begin
            w_tail_nxt = w_head_nxt;
            w_used_nxt = '0;
        end else if (w_alloc) begin
            w_tail_nxt = r_tail + RRF_SEL'(w_req);
            w_used_nxt = r_used - w_com + w_req;
        end else begin
            w_tail_nxt = r_tail;
            w_used_nxt = r_used - w_com;
        end
        for (int i = 0; i < NWR; i++) begin
            w_valid_nxt[wr_tag[i*RRF_SEL +: RRF_SEL]] =
                w_valid_nxt[wr_tag[i*RRF_SEL +: RRF_SEL]] | (wr_en[i] & ~flush);
        end
        for (int e = 0; e < RRF_NUM; e++) begin
            w_off_h = RRF_SEL'(e) - r_head;
            w_off_t = RRF_SEL'(e) - r_tail;
            w_valid_nxt[e] = w_valid_nxt[e]
                & ~(flush & (CW'(w_off_h) >= w_com) & (CW'(w_off_h) < r_used))
                & ~(w_alloc & (CW'(w_off_t) < w_req));
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_used  <= '0;
            r_valid <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_used  <= w_used_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Data array, not reset; the highest-indexed port lands last on a shared tag.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                r_data[wr_tag[i*RRF_SEL +: RRF_SEL]] <= wr_data[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

    // Operand and commit read-out.
    always_comb begin
        rd_data   = '0;
        rd_valid  = '0;
        com_data  = '0;
        com_valid = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*DATA_LEN +: DATA_LEN] = r_data[rd_tag[i*RRF_SEL +: RRF_SEL]];
            rd_valid[i]                     = r_valid[rd_tag[i*RRF_SEL +: RRF_SEL]];
`ifdef RRF_WR_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_tag[j*RRF_SEL +: RRF_SEL] == rd_tag[i*RRF_SEL +: RRF_SEL])) begin
                    rd_data[i*DATA_LEN +: DATA_LEN] = wr_data[j*DATA_LEN +: DATA_LEN];
                    rd_valid[i]                     = 1'b1;
                end else begin
                    rd_valid[i] = rd_valid[i];
                end
            end
`endif
        end
        for (int k = 0; k < NCM; k++) begin
            com_data[k*DATA_LEN +: DATA_LEN] = r_data[r_head + RRF_SEL'(k)];
            com_valid[k]                     = r_valid[r_head + RRF_SEL'(k)];
`ifdef RRF_WR_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_tag[j*RRF_SEL +: RRF_SEL] == (r_head + RRF_SEL'(k)))) begin
                    com_data[k*DATA_LEN +: DATA_LEN] = wr_data[j*DATA_LEN +: DATA_LEN];
                    com_valid[k]                     = 1'b1;
                end else begin
                    com_valid[k] = com_valid[k];
                end
            end
`endif
        end
    end

    // Allocated tag slots are shown whenever requested, regardless of the grant.
    always_comb begin
        dp_tag = '0;
        for (int k = 0; k < NDP; k++) begin
            dp_tag[k*RRF_SEL +: RRF_SEL] = (w_req > CW'(k)) ? (r_tail + RRF_SEL'(k)) : '0;
        end
    end

    assign dp_ack   = w_ack;
    assign free_cnt = w_free;
    assign rrf_head = r_head;
    assign rrf_tail = r_tail;

endmodule

// File: tb/tb_rrf_alloc.sv
// Directed bench for rrf_alloc: queue-level model checked every cycle plus hand-computed checkpoints.
module tb_rrf_alloc;
    localparam int DL = 32, N = 64, SEL = 6, NRD = 4, NWR = 5, NDP = 2, NCM = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NRD*SEL-1:0] rd_tag;
    logic [NRD*DL-1:0]  rd_data;
    logic [NRD-1:0]     rd_valid;
    logic [NWR-1:0]     wr_en;
    logic [NWR*SEL-1:0] wr_tag;
    logic [NWR*DL-1:0]  wr_data;
    logic [1:0]         dp_req;
    logic               dp_ack;
    logic [NDP*SEL-1:0] dp_tag;
    logic [1:0]         com_num;
    logic [NCM*DL-1:0]  com_data;
    logic [NCM-1:0]     com_valid;
    logic               flush;
    logic [SEL:0]       free_cnt;
    logic [SEL-1:0]     rrf_head;
    logic [SEL-1:0]     rrf_tail;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int            m_head, m_tail, m_used;
    bit            m_valid [N];
    bit            m_known [N];
    logic [DL-1:0] m_data  [N];

    rrf_alloc #(.DATA_LEN(DL), .RRF_NUM(N), .RRF_SEL(SEL), .NRD(NRD), .NWR(NWR), .NDP(NDP), .NCM(NCM)) dut (
        .clk(clk), .reset(reset),
        .rd_tag(rd_tag), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_tag(wr_tag), .wr_data(wr_data),
        .dp_req(dp_req), .dp_ack(dp_ack), .dp_tag(dp_tag),
        .com_num(com_num), .com_data(com_data), .com_valid(com_valid),
        .flush(flush), .free_cnt(free_cnt), .rrf_head(rrf_head), .rrf_tail(rrf_tail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int eff_req();
        return (int'(dp_req) > NDP) ? NDP : int'(dp_req);
    endfunction

    function automatic int eff_com();
        int c;
        c = int'(com_num);
        if (c > NCM) c = NCM;
        if (c > m_used) c = m_used;
        return c;
    endfunction

    function automatic bit exp_ack();
        return !flush && (eff_req() <= (N - m_used) + eff_com());
    endfunction

    task automatic exp_read(input int t, output logic [DL-1:0] d, output bit v, output bit k);
        d = m_data[t];
        v = m_valid[t];
        k = m_known[t];
`ifdef RRF_WR_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && int'(wr_tag[j*SEL +: SEL]) == t) begin
                d = wr_data[j*DL +: DL];
                v = 1'b1;
                k = 1'b1;
            end
        end
`endif
    endtask

    task automatic model_reset();
        m_head = 0;
        m_tail = 0;
        m_used = 0;
        for (int e = 0; e < N; e++) m_valid[e] = 1'b0;
    endtask

    task automatic model_step();
        int req;
        int cm;
        bit ack;
        req = eff_req();
        cm  = eff_com();
        ack = exp_ack();
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                m_data[int'(wr_tag[i*SEL +: SEL])]  = wr_data[i*DL +: DL];
                m_known[int'(wr_tag[i*SEL +: SEL])] = 1'b1;
                if (!flush) m_valid[int'(wr_tag[i*SEL +: SEL])] = 1'b1;
            end
        end
        if (flush) begin
            for (int j = cm; j < m_used; j++) m_valid[(m_head + j) % N] = 1'b0;
            m_head = (m_head + cm) % N;
            m_tail = m_head;
            m_used = 0;
        end else begin
            m_head = (m_head + cm) % N;
            m_used = m_used - cm;
            if (ack && req > 0) begin
                for (int k = 0; k < req; k++) m_valid[(m_tail + k) % N] = 1'b0;
                m_tail = (m_tail + req) % N;
                m_used = m_used + req;
            end
        end
    endtask

    task automatic compare();
        logic [DL-1:0] d;
        bit v;
        bit k;
        chk("free_cnt", free_cnt, N - m_used);
        chk("dp_ack", dp_ack, exp_ack());
        chk("rrf_head", rrf_head, m_head);
        chk("rrf_tail", rrf_tail, m_tail);
        for (int s = 0; s < eff_req(); s++)
            chk($sformatf("dp_tag[%0d]", s), dp_tag[s*SEL +: SEL], (m_tail + s) % N);
        for (int i = 0; i < NRD; i++) begin
            exp_read(int'(rd_tag[i*SEL +: SEL]), d, v, k);
            chk($sformatf("rd_valid[%0d]", i), rd_valid[i], v);
            if (k) chk($sformatf("rd_data[%0d]", i), rd_data[i*DL +: DL], d);
        end
        for (int s = 0; s < NCM; s++) begin
            exp_read((m_head + s) % N, d, v, k);
            chk($sformatf("com_valid[%0d]", s), com_valid[s], v);
            if (k) chk($sformatf("com_data[%0d]", s), com_data[s*DL +: DL], d);
        end
    endtask

    always @(negedge clk) begin
        if (reset && chk_en) compare();
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wr_en   = '0;
        dp_req  = 2'd0;
        com_num = 2'd0;
        flush   = 1'b0;
    endtask

    task automatic wr(input int p, input int t, input logic [DL-1:0] d);
        wr_en[p]            = 1'b1;
        wr_tag[p*SEL +: SEL] = SEL'(t);
        wr_data[p*DL +: DL]  = d;
    endtask

    task automatic set_rd(input int p, input int t);
        rd_tag[p*SEL +: SEL] = SEL'(t);
    endtask

    initial begin
        idle();
        rd_tag  = '0;
        wr_tag  = '0;
        wr_data = '0;
        model_reset();
        for (int e = 0; e < N; e++) m_known[e] = 1'b0;
        #2;
        chk("rst free_cnt", free_cnt, 64);
        chk("rst dp_ack", dp_ack, 1);
        chk("rst head", rrf_head, 0);
        chk("rst tail", rrf_tail, 0);
        chk("rst rd_valid", rd_valid, 4'b0000);
        #5;
        reset  = 1'b1;
        chk_en = 1'b1;

        // fill the file two tags per cycle
        dp_req = 2'd2;
        for (int c = 0; c < 32; c++) begin
            chk("fill dp_tag0", dp_tag[SEL-1:0], 2 * c);
            cyc();
        end
        chk("full tail", rrf_tail, 0);
        chk("full free_cnt", free_cnt, 0);
        chk("full dp_ack", dp_ack, 0);
        wr(0, 0, 32'h100);
        wr(1, 1, 32'h101);
        cyc();
        chk("full tail held", rrf_tail, 0);

        // commit two and reissue them in the same cycle
        idle();
        dp_req  = 2'd2;
        com_num = 2'd2;
        #1;
        chk("recycle dp_ack", dp_ack, 1);
        chk("recycle slot0", dp_tag[SEL-1:0], 0);
        chk("recycle slot1", dp_tag[2*SEL-1:SEL], 1);
        chk("recycle com_valid", com_valid, 2'b11);
        cyc();
        idle();
        set_rd(0, 0);
        set_rd(1, 1);
        #1;
        chk("recycle free_cnt", free_cnt, 0);
        chk("recycle valid cleared", rd_valid[1:0], 2'b00);
        chk("recycle head", rrf_head, 2);

        // single writeback on port 4
        wr(4, 5, 32'hDEADBEEF);
        set_rd(2, 5);
        #1;
`ifdef RRF_WR_BYPASS_EN
        chk("bypass data", rd_data[2*DL +: DL], 32'hDEADBEEF);
        chk("bypass valid", rd_valid[2], 1);
`endif
        cyc();
        idle();
        #1;
        chk("wb valid", rd_valid[2], 1);
        chk("wb data", rd_data[2*DL +: DL], 32'hDEADBEEF);

        // two ports write one tag: highest port wins
        wr(0, 9, 32'h11);
        wr(3, 9, 32'h33);
        set_rd(3, 9);
        cyc();
        idle();
        #1;
        chk("dual wr data", rd_data[3*DL +: DL], 32'h33);
        chk("dual wr valid", rd_valid[3], 1);

        // set up head=10, tail=20
        com_num = 2'd2;
        repeat (4) cyc();
        idle();
        chk("pre head", rrf_head, 10);
        chk("pre free_cnt", free_cnt, 8);
        flush = 1'b1;
        #1;
        chk("flush0 dp_ack", dp_ack, 0);
        cyc();
        idle();
        chk("flush0 tail", rrf_tail, 10);
        chk("flush0 free_cnt", free_cnt, 64);
        dp_req = 2'd2;
        repeat (5) cyc();
        idle();
        chk("pre tail", rrf_tail, 20);
        for (int p = 0; p < NWR; p++) wr(p, 10 + p, 32'hA0 + p);
        cyc();
        idle();
        for (int p = 0; p < NWR; p++) wr(p, 15 + p, 32'hB0 + p);
        cyc();
        idle();
        set_rd(0, 11);
        set_rd(1, 19);
        set_rd(2, 10);
        set_rd(3, 15);
        #1;
        chk("pre-flush valid", rd_valid, 4'b1111);
        flush   = 1'b1;
        com_num = 2'd1;
        dp_req  = 2'd2;
        wr(0, 15, 32'h5555);
        #1;
        chk("flush dp_ack", dp_ack, 0);
        cyc();
        idle();
        #1;
        chk("flush tail", rrf_tail, 11);
        chk("flush head", rrf_head, 11);
        chk("flush free_cnt", free_cnt, 64);
        chk("flush valid", rd_valid, 4'b0100);
        chk("flush wb data", rd_data[3*DL +: DL], 32'h5555);

        // dispatch to tail=40, then asynchronous reset mid-dispatch
        dp_req = 2'd1;
        cyc();
        dp_req = 2'd2;
        repeat (14) cyc();
        set_rd(0, 10);
        set_rd(1, 5);
        set_rd(2, 9);
        set_rd(3, 0);
        #1;
        chk("pre-rst tail", rrf_tail, 40);
        chk("pre-rst valid", rd_valid, 4'b0111);
        reset = 1'b0;
        #1;
        chk("async rst head", rrf_head, 0);
        chk("async rst tail", rrf_tail, 0);
        chk("async rst free_cnt", free_cnt, 64);
        chk("async rst rd_valid", rd_valid, 4'b0000);
        model_reset();
        #3;
        reset = 1'b1;
        idle();

        // commit on an empty file is clamped; over-range request behaves as NDP
        com_num = 2'd2;
        cyc();
        idle();
        dp_req = 2'd3;
        #1;
        chk("clamp dp_ack", dp_ack, 1);
        cyc();
        idle();
        chk("clamp tail", rrf_tail, 2);
        chk("clamp head", rrf_head, 0);

        // steady allocate/write/commit stream wrapping both pointers
        for (int c = 0; c < 40; c++) begin
            idle();
            dp_req  = 2'd2;
            com_num = (c >= 2) ? 2'd2 : 2'd0;
            wr(0, (2 * c) % N, 32'hC000 + c);
            wr(4, (2 * c + 1) % N, 32'hD000 + c);
            set_rd(0, (2 * c) % N);
            set_rd(1, (2 * c + 63) % N);
            cyc();
        end
        idle();
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
